// File: rtl/expr_pipe_pkg.sv
// Shared opcode encoding and width helper for the pipelined expression evaluator.
package expr_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ASHR = 4'd11,
    OP_LT   = 4'd12,
    OP_EQ   = 4'd13,
    OP_RAND = 4'd14,
    OP_RXOR = 4'd15
  } op_e;

  // Internal evaluation width: max(WA, WY).
  function automatic int unsigned wi_width(input int unsigned wa, input int unsigned wy);
    return (wa > wy) ? wa : wy;
  endfunction

endpackage

// File: rtl/expr_alu_ch.sv
// Combinational single-channel ALU following Verilog expression width and sign rules.
module expr_alu_ch
  import expr_pipe_pkg::*;
#(
  parameter int unsigned WA = 6,
  parameter int unsigned WY = 6
) (
  input  op_e           op,
  input  logic [WA-1:0] a,
  input  logic [WA-1:0] b,
  input  logic          a_sgn,
  input  logic          b_sgn,
  output logic [WY-1:0] r,
  output logic          err
);

  localparam int unsigned WI = wi_width(WA, WY);

  logic                 sgn;
  logic                 bz;
  logic [WI-1:0]        ax;
  logic [WI-1:0]        bx;
  logic [WI-1:0]        res;
  logic signed [WI-1:0] as_w;
  logic signed [WI-1:0] bs_w;

  always_comb begin
    // Mixed signedness degrades the whole expression to unsigned.
    sgn  = a_sgn & b_sgn;
    ax   = sgn ? WI'($signed(a)) : WI'(a);
    bx   = sgn ? WI'($signed(b)) : WI'(b);
    as_w = $signed(ax);
    bs_w = $signed(bx);
    bz   = (b == '0);
    res  = '0;
    err  = 1'b0;
    unique case (op)
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_MUL:  res = ax * bx;
      OP_DIV: begin
        if (bz)       err = 1'b1;
        else if (sgn) res = $unsigned(as_w / bs_w);
        else          res = ax / bx;
      end
      OP_MOD: begin
        if (bz)       err = 1'b1;
        else if (sgn) res = $unsigned(as_w % bs_w);
        else          res = ax % bx;
      end
      OP_AND:  res = ax & bx;
      OP_OR:   res = ax | bx;
      OP_XOR:  res = ax ^ bx;
      OP_XNOR: res = ~(ax ^ bx);
      // Shift amounts use the raw operand, always unsigned.
      OP_SHL:  res = ax << b;
      OP_SHR:  res = ax >> b;
      OP_ASHR: res = sgn ? $unsigned(as_w >>> b) : (ax >> b);
      OP_LT:   res = WI'(sgn ? (as_w < bs_w) : (ax < bx));
      OP_EQ:   res = WI'(ax == bx);
      OP_RAND: res = WI'(&a);
      OP_RXOR: res = WI'(^a);
      default: res = '0;
    endcase
    r = res[WY-1:0];
  end

endmodule

// File: rtl/expr_pipe_eval.sv
// Two-stage valid/ready pipeline wrapping NCH expression ALU channels, with error and
// delivery bookkeeping.
module expr_pipe_eval
  import expr_pipe_pkg::*;
#(
  parameter int unsigned WA  = 6,
  parameter int unsigned WY  = 6,
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NCH-1:0]  op,
  input  logic [WA*NCH-1:0] a,
  input  logic [WA*NCH-1:0] b,
  input  logic [NCH-1:0]    a_sgn,
  input  logic [NCH-1:0]    b_sgn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WY*NCH-1:0] y,
  output logic [NCH-1:0]    y_err,
  output logic [NCH-1:0]    err_sticky,
  input  logic              err_clr,
  output logic [CW-1:0]     txn_count
);

  logic              s1_v_q;
  logic [4*NCH-1:0]  s1_op_q;
  logic [WA*NCH-1:0] s1_a_q;
  logic [WA*NCH-1:0] s1_b_q;
  logic [NCH-1:0]    s1_as_q;
  logic [NCH-1:0]    s1_bs_q;

  logic              s2_v_q;
  logic [WY*NCH-1:0] y_q;
  logic [NCH-1:0]    y_err_q;
  logic [NCH-1:0]    err_sticky_q, err_sticky_d;
  logic [CW-1:0]     txn_count_q, txn_count_d;

  logic [WY*NCH-1:0] alu_y;
  logic [NCH-1:0]    alu_err;

  logic deliver;
  logic s2_load;
  logic s1_adv;
  logic accept;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    op_e ch_op;
    assign ch_op = op_e'(s1_op_q[4*ch +: 4]);

    expr_alu_ch #(
      .WA(WA),
      .WY(WY)
    ) u_alu (
      .op   (ch_op),
      .a    (s1_a_q[WA*ch +: WA]),
      .b    (s1_b_q[WA*ch +: WA]),
      .a_sgn(s1_as_q[ch]),
      .b_sgn(s1_bs_q[ch]),
      .r    (alu_y[WY*ch +: WY]),
      .err  (alu_err[ch])
    );
  end

  // Each stage loads when empty or when its current contents move on this cycle.
  always_comb begin
    deliver      = s2_v_q && out_ready;
    s2_load      = !s2_v_q || out_ready;
    s1_adv       = s1_v_q && s2_load;
    in_ready     = !s1_v_q || s1_adv;
    accept       = in_valid && in_ready;
    err_sticky_d = (err_clr ? '0 : err_sticky_q) | (deliver ? y_err_q : '0);
    txn_count_d  = deliver ? txn_count_q + CW'(1) : txn_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q       <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_as_q      <= '0;
      s1_bs_q      <= '0;
      s2_v_q       <= 1'b0;
      y_q          <= '0;
      y_err_q      <= '0;
      err_sticky_q <= '0;
      txn_count_q  <= '0;
    end else begin
      if (in_ready) s1_v_q <= in_valid;
      if (accept) begin
        s1_op_q <= op;
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_as_q <= a_sgn;
        s1_bs_q <= b_sgn;
      end
      if (s2_load) s2_v_q <= s1_v_q;
      if (s1_adv) begin
        y_q     <= alu_y;
        y_err_q <= alu_err;
      end
      err_sticky_q <= err_sticky_d;
      txn_count_q  <= txn_count_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign y          = y_q;
  assign y_err      = y_err_q;
  assign err_sticky = err_sticky_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Directed self-checking bench for expr_pipe_eval with WA=WY=6, NCH=4.
module tb_expr_pipe_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op;
  logic [23:0] a;
  logic [23:0] b;
  logic [3:0]  a_sgn;
  logic [3:0]  b_sgn;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] y;
  logic [3:0]  y_err;
  logic [3:0]  err_sticky;
  logic        err_clr;
  logic [15:0] txn_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  expr_pipe_eval #(
    .WA (6),
    .WY (6),
    .NCH(4),
    .CW (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .a_sgn     (a_sgn),
    .b_sgn     (b_sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_err     (y_err),
    .err_sticky(err_sticky),
    .err_clr   (err_clr),
    .txn_count (txn_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] o, input logic [23:0] av, input logic [23:0] bv,
                       input logic [3:0] as, input logic [3:0] bs);
    op    = o;
    a     = av;
    b     = bv;
    a_sgn = as;
    b_sgn = bs;
  endtask

  // One beat into an empty pipe with out_ready high; checks 2-cycle latency and result.
  task automatic run1(input string tag, input logic [15:0] o, input logic [23:0] av,
                      input logic [23:0] bv, input logic [3:0] as, input logic [3:0] bs,
                      input logic [23:0] ey, input logic [3:0] ee);
    drive(o, av, bv, as, bs);
    in_valid = 1'b1;
    #1;
    check({tag, ".rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({tag, ".lat1"}, out_valid, 0);
    tick();
    check({tag, ".lat2"}, out_valid, 1);
    check({tag, ".y"}, y, ey);
    check({tag, ".err"}, y_err, ee);
  endtask

  function automatic logic [23:0] stall_a(input int k);
    logic [23:0] v;
    for (int c = 0; c < 4; c++) v[6*c +: 6] = 6'(k + c);
    return v;
  endfunction

  function automatic logic [23:0] stall_y(input int k);
    logic [23:0] v;
    for (int c = 0; c < 4; c++) v[6*c +: 6] = 6'(k + c + 10);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  acc;
    int  dlv;
    logic hs_in;
    logic hs_out;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    drive(16'h0, 24'h0, 24'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.ov", out_valid, 0);
    check("rst.y", y, 0);
    check("rst.yerr", y_err, 0);
    check("rst.sticky", err_sticky, 0);
    check("rst.txn", txn_count, 0);
    check("rst.rdy", in_ready, 1);

    // ch0 ADD signed, ch1 LT mixed, ch2 LT signed, ch3 DIV by zero
    run1("A", 16'h3CC0, {6'h07, 6'h3F, 6'h3F, 6'h3D}, {6'h00, 6'h01, 6'h01, 6'h05},
         4'b0111, 4'b0101, {6'h00, 6'h01, 6'h00, 6'h02}, 4'b1000);
    tick();
    check("A.sticky", err_sticky, 4'b1000);
    check("A.txn", txn_count, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr.sticky", err_sticky, 0);

    // ch0 DIV min/-1 signed, ch1 ASHR signed, ch2 ASHR unsigned, ch3 SHL by 7
    run1("B", 16'h9BB3, {6'h01, 6'h30, 6'h30, 6'h20}, {6'h07, 6'h02, 6'h02, 6'h3F},
         4'b0011, 4'b0011, {6'h00, 6'h0C, 6'h3C, 6'h20}, 4'b0000);
    // ch0 MOD signed, ch1 MUL, ch2 RXOR, ch3 XNOR
    run1("C", 16'h8F24, {6'h0F, 6'h07, 6'h05, 6'h39}, {6'h33, 6'h00, 6'h07, 6'h02},
         4'b0001, 4'b0001, {6'h03, 6'h01, 6'h23, 6'h3F}, 4'b0000);
    // ch0 SUB wrap, ch1 EQ, ch2 RAND, ch3 DIV mixed-sign treated unsigned
    run1("D", 16'h3ED1, {6'h3F, 6'h3F, 6'h09, 6'h02}, {6'h02, 6'h00, 6'h09, 6'h05},
         4'b1000, 4'b0000, {6'h1F, 6'h01, 6'h01, 6'h3D}, 4'b0000);
    // ch3 MOD by zero, delivered in the same cycle as an err_clr pulse
    run1("E", 16'h4000, {6'h05, 6'h00, 6'h00, 6'h00}, 24'h0,
         4'b0000, 4'b0000, 24'h0, 4'b1000);
    check("E.txn_pre", txn_count, 4);
    check("E.sticky_pre", err_sticky, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("E.sticky_win", err_sticky, 4'b1000);
    check("E.txn", txn_count, 5);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2.txn", txn_count, 0);
    check("rst2.sticky", err_sticky, 0);

    // Back-to-back beats against a 6-cycle downstream stall
    acc = 0;
    dlv = 0;
    for (int cyc = 0; cyc < 40 && dlv < 5; cyc++) begin
      out_ready = (cyc >= 6);
      if (acc < 5) begin
        in_valid = 1'b1;
        drive(16'h0000, stall_a(acc), {4{6'd10}}, 4'h0, 4'h0);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 5) begin
        check("stall.acc", acc, 2);
        check("stall.rdy", in_ready, 0);
        check("stall.ov", out_valid, 1);
        check("stall.hold", y, stall_y(0));
      end
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        check($sformatf("stall.y%0d", dlv), y, stall_y(dlv));
        dlv++;
      end
      tick();
      if (hs_in) acc++;
    end
    in_valid = 1'b0;
    check("stall.dlv", dlv, 5);
    check("stall.txn", txn_count, 5);

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(16'h0000, stall_a(20), {4{6'd1}}, 4'h0, 4'h0);
    tick();
    drive(16'h0000, stall_a(30), {4{6'd1}}, 4'h0, 4'h0);
    tick();
    in_valid = 1'b0;
    check("fly.ov", out_valid, 1);
    reset = 1'b1;
    tick();
    check("fly.ov_rst", out_valid, 0);
    check("fly.txn_rst", txn_count, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    check("fly.rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fly.stale%0d", i), out_valid, 0);
    end
    check("fly.txn", txn_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
